// File: rtl/weight_ram_loader_pkg.sv
// ============================================================================
// weight_pkg : shared constants and state type for the weight RAM loader
// Rev 1.0
// ============================================================================
`default_nettype none

package weight_pkg;

   localparam int W_WIDTH     = 16;
   localparam int W_ADDR      = 5;
   localparam int W_NUM       = 64;
   localparam int W_DEPTH     = 27;
   localparam int TOTAL_WORDS = W_NUM * W_DEPTH;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      LOADED = 2'd2
   } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/weight_ram_loader_if.sv
// ============================================================================
// weight_ram_loader_if : weight stream input and parallel read bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface weight_ram_loader_if #(
   parameter int WIDTH = 16,
   parameter int ADDR  = 5,
   parameter int NUM   = 64
);
   logic [WIDTH-1:0] s_data;
   logic             s_valid;
   logic             s_ready;
   logic             rd_req;
   logic [ADDR-1:0]  address;
   logic             rd_valid;
   logic [WIDTH-1:0] rom_out [NUM];

   modport master (
      output s_data, s_valid, rd_req, address,
      input  s_ready, rd_valid, rom_out
   );

   modport slave (
      input  s_data, s_valid, rd_req, address,
      output s_ready, rd_valid, rom_out
   );
endinterface

`default_nettype wire

// File: rtl/weight_ram_loader_bank.sv
// ============================================================================
// weight_bank : one distributed RAM bank, synchronous write, registered read
// Rev 1.0
// ============================================================================
`default_nettype none

module weight_bank #(
   parameter int WIDTH = 16,
   parameter int ADDR  = 5
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             we,
   input  wire logic [ADDR-1:0]  wr_addr,
   input  wire logic [WIDTH-1:0] wr_data,
   input  wire logic             rd_en,
   input  wire logic [ADDR-1:0]  rd_addr,
   output logic      [WIDTH-1:0] rd_data
);

   (* rom_style = "distributed", ram_style = "distributed" *)
   logic [WIDTH-1:0] r_mem [2**ADDR];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   // Only the output register is reset; array contents are left uninitialised.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= r_mem[rd_addr];
      end
   end

endmodule

`default_nettype wire

// File: rtl/weight_ram_loader.sv
// ============================================================================
// weight_ram_loader : streams weights bank-major into NUM RAM banks and
//                     serves a parallel one-address, NUM-word read
// Rev 1.0
// ============================================================================
`default_nettype none

module weight_ram_loader
   import weight_pkg::*;
#(
   parameter int WIDTH = W_WIDTH,
   parameter int ADDR  = W_ADDR,
   parameter int NUM   = W_NUM,
   parameter int DEPTH = W_DEPTH
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   input  wire logic          start,
   output logic               busy,
   output logic               done,
   output logic               loaded,
   weight_ram_loader_if.slave bus
);

   localparam int C_BANK_W = (NUM > 1) ? $clog2(NUM) : 1;

   loader_state_t        r_state;
   loader_state_t        w_state_nxt;
   logic [C_BANK_W-1:0]  r_bank_cnt;
   logic [ADDR-1:0]      r_addr_cnt;
   logic                 r_done;
   logic                 r_rd_valid;
   logic                 r_oob;

   logic                 w_hs;
   logic                 w_addr_last;
   logic                 w_word_last;
   logic                 w_start_load;
   logic                 w_rd_acc;
   logic                 w_oob;
   logic [WIDTH-1:0]     w_q [NUM];

   assign w_hs         = bus.s_valid && (r_state == LOAD);
   assign w_addr_last  = (r_addr_cnt == ADDR'(DEPTH - 1));
   assign w_word_last  = w_addr_last && (r_bank_cnt == C_BANK_W'(NUM - 1));
   assign w_start_load = start && (r_state != LOAD);
   // A start in LOADED takes priority and drops any concurrent read.
   assign w_rd_acc     = bus.rd_req && (r_state == LOADED) && !start;
   assign w_oob        = ({1'b0, bus.address} >= (ADDR + 1)'(DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = LOAD;
         LOAD:    if (w_hs && w_word_last) w_state_nxt = LOADED;
         LOADED:  if (start) w_state_nxt = LOAD;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bank_cnt <= '0;
         r_addr_cnt <= '0;
      end else if (w_start_load) begin
         r_bank_cnt <= '0;
         r_addr_cnt <= '0;
      end else if (w_hs) begin
         if (w_addr_last) begin
            r_addr_cnt <= '0;
            r_bank_cnt <= w_word_last ? '0 : r_bank_cnt + 1'b1;
         end else begin
            r_addr_cnt <= r_addr_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done     <= 1'b0;
         r_rd_valid <= 1'b0;
         r_oob      <= 1'b0;
      end else begin
         r_done     <= w_hs && w_word_last;
         r_rd_valid <= w_rd_acc;
         if (w_rd_acc) begin
            r_oob <= w_oob;
         end
      end
   end

   generate
      for (genvar k = 0; k < NUM; k++) begin : g_bank
         weight_bank #(
            .WIDTH (WIDTH),
            .ADDR  (ADDR)
         ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .we      (w_hs && (r_bank_cnt == C_BANK_W'(k))),
            .wr_addr (r_addr_cnt),
            .wr_data (bus.s_data),
            .rd_en   (w_rd_acc),
            .rd_addr (bus.address),
            .rd_data (w_q[k])
         );
         assign bus.rom_out[k] = r_oob ? '0 : w_q[k];
      end
   endgenerate

   assign bus.s_ready  = (r_state == LOAD);
   assign bus.rd_valid = r_rd_valid;
   assign busy         = (r_state == LOAD);
   assign loaded       = (r_state == LOADED);
   assign done         = r_done;

endmodule

`default_nettype wire

// File: tb/tb_weight_ram_loader.sv
// ============================================================================
// tb_weight_ram_loader : directed self-checking bench for weight_ram_loader
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_weight_ram_loader;
   import weight_pkg::*;

   localparam int WIDTH = W_WIDTH;
   localparam int ADDR  = W_ADDR;
   localparam int NUM   = W_NUM;
   localparam int DEPTH = W_DEPTH;
   localparam int TOTAL = TOTAL_WORDS;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic busy, done, loaded;

   weight_ram_loader_if #(.WIDTH(WIDTH), .ADDR(ADDR), .NUM(NUM)) bus ();

   weight_ram_loader #(
      .WIDTH (WIDTH),
      .ADDR  (ADDR),
      .NUM   (NUM),
      .DEPTH (DEPTH)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .busy   (busy),
      .done   (done),
      .loaded (loaded),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   logic [WIDTH-1:0] model [NUM][DEPTH];

   typedef struct {
      logic            req;
      logic [ADDR-1:0] addr;
      logic            exp_v;
      logic [15:0]     e0;
      logic [15:0]     e1;
      logic [15:0]     e63;
   } rvec_t;

   rvec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic do_read(input logic req, input logic [ADDR-1:0] a);
      @(negedge clk);
      bus.rd_req  = req;
      bus.address = a;
      @(posedge clk);
      #1 bus.rd_req = 1'b0;
   endtask

   // Compares every bank output with the scoreboard for address a.
   task automatic check_all_banks(input string name, input logic [ADDR-1:0] a);
      int bad = 0;
      for (int k = 0; k < NUM; k++) begin
         logic [WIDTH-1:0] exp;
         exp = (int'(a) < DEPTH) ? model[k][a] : '0;
         if (bus.rom_out[k] !== exp) bad++;
      end
      check(name, bad, 0);
   endtask

   task automatic load_words(input bit invert, input int duty, input int stop_at,
                             input bit poke, output int n);
      int cyc = 0;
      bit hs;
      bit ready_bad = 0, loaded_bad = 0, rdv_bad = 0, done_bad = 0, poked = 0;
      n = 0;
      while (n < stop_at && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         bus.s_valid = ($urandom_range(0, 99) < duty);
         bus.s_data  = invert ? WIDTH'(32'hFFFF - n) : WIDTH'(n);
         start       = poke && (n == 500) && !poked;
         if (start) poked = 1;
         bus.rd_req  = (n == 300);
         bus.address = 5'd3;
         #1 hs = bus.s_valid && bus.s_ready;
         if (!bus.s_ready || !busy) ready_bad = 1;
         if (loaded) loaded_bad = 1;
         @(posedge clk);
         #1;
         if (hs) begin
            model[n / DEPTH][n % DEPTH] = bus.s_data;
            n++;
         end
         if (bus.rd_valid) rdv_bad = 1;
         if (done !== (hs && n == TOTAL)) done_bad = 1;
      end
      bus.s_valid = 1'b0;
      start       = 1'b0;
      bus.rd_req  = 1'b0;
      check("load_ready_busy_high", ready_bad, 0);
      check("load_loaded_low", loaded_bad, 0);
      check("load_rd_valid_low", rdv_bad, 0);
      check("load_done_timing", done_bad, 0);
      check("load_within_budget", (cyc < 40000), 1);
   endtask

   task automatic after_done();
      @(posedge clk);
      #1;
      check("done_single_cycle", done, 0);
      check("loaded_after_done", loaded, 1);
      check("busy_after_done", busy, 0);
   endtask

   initial begin
      int n;
      bus.s_data  = '0;
      bus.s_valid = 1'b0;
      bus.rd_req  = 1'b0;
      bus.address = '0;

      vecs[0] = '{1'b1, 5'd5,  1'b1, 16'd5,  16'd32, 16'd1706};
      vecs[1] = '{1'b0, 5'd9,  1'b0, 16'd5,  16'd32, 16'd1706};
      vecs[2] = '{1'b1, 5'd0,  1'b1, 16'd0,  16'd27, 16'd1701};
      vecs[3] = '{1'b1, 5'd26, 1'b1, 16'd26, 16'd53, 16'd1727};
      vecs[4] = '{1'b1, 5'd27, 1'b1, 16'd0,  16'd0,  16'd0};
      vecs[5] = '{1'b1, 5'd30, 1'b1, 16'd0,  16'd0,  16'd0};
      vecs[6] = '{1'b1, 5'd31, 1'b1, 16'd0,  16'd0,  16'd0};
      vecs[7] = '{1'b1, 5'd1,  1'b1, 16'd1,  16'd28, 16'd1702};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_s_ready", bus.s_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_loaded", loaded, 0);
      rst_n = 1'b1;
      #1;
      check("rst_done", done, 0);
      check("rst_rd_valid", bus.rd_valid, 0);
      check("rst_rom_out0", bus.rom_out[0], 0);

      do_read(1'b1, 5'd5);
      check("idle_rd_ignored", bus.rd_valid, 0);

      // Full load, s_valid held high, stray start at word 500
      pulse_start();
      load_words(1'b0, 100, TOTAL, 1'b1, n);
      check("full_load_count", n, TOTAL);
      after_done();

      for (int i = 0; i < 8; i++) begin
         do_read(vecs[i].req, vecs[i].addr);
         check($sformatf("vec%0d_rd_valid", i), bus.rd_valid, vecs[i].exp_v);
         check($sformatf("vec%0d_rom0", i), bus.rom_out[0], vecs[i].e0);
         check($sformatf("vec%0d_rom1", i), bus.rom_out[1], vecs[i].e1);
         check($sformatf("vec%0d_rom63", i), bus.rom_out[63], vecs[i].e63);
         if (vecs[i].req) check_all_banks($sformatf("vec%0d_all_banks", i), vecs[i].addr);
      end

      // start and rd_req together in LOADED: start wins
      @(negedge clk);
      start       = 1'b1;
      bus.rd_req  = 1'b1;
      bus.address = 5'd5;
      @(posedge clk);
      #1;
      start      = 1'b0;
      bus.rd_req = 1'b0;
      check("start_rd_rd_valid", bus.rd_valid, 0);
      check("start_rd_busy", busy, 1);
      check("start_rd_loaded", loaded, 0);

      // Backpressure load at ~30% duty
      load_words(1'b0, 30, TOTAL, 1'b0, n);
      check("bp_load_count", n, TOTAL);
      after_done();
      do_read(1'b1, 5'd5);
      check("bp_rd_valid", bus.rd_valid, 1);
      check("bp_rom63", bus.rom_out[63], 16'd1706);
      check_all_banks("bp_all_banks", 5'd5);

      // Reset after 100 handshakes
      pulse_start();
      load_words(1'b0, 100, 100, 1'b0, n);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_s_ready", bus.s_ready, 0);
      check("midrst_busy", busy, 0);
      check("midrst_loaded", loaded, 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_read(1'b1, 5'd5);
      check("midrst_rd_valid", bus.rd_valid, 0);

      // Reload with inverted data
      pulse_start();
      load_words(1'b1, 100, TOTAL, 1'b0, n);
      check("reload_count", n, TOTAL);
      after_done();
      do_read(1'b1, 5'd0);
      check("reload_rd_valid", bus.rd_valid, 1);
      check("reload_rom0", bus.rom_out[0], 16'hFFFF);
      check("reload_rom1", bus.rom_out[1], 16'hFFE4);
      check_all_banks("reload_all_banks", 5'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
